// File: rtl/serial_subtractor16.sv
// Multi-cycle LSB-first subtractor: diff = a - b - bin, BPC bits per cycle.
// Ports: clk, rst_n, start, a, b, bin -> busy, done, diff, bout, ovf.
module serial_subtractor16 #(
    parameter int WIDTH = 16,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_bpc
        $error("serial_subtractor16: BPC must divide WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             br_q;
    logic             br_d;
    logic             sa_q;
    logic             sb_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    // One slice: BPC-bit borrow ripple over the low bits of the
    // operand shift registers; result bits enter at the MSB end.
    always_comb begin
        logic             br;
        logic             ai;
        logic             bi;
        logic [BPC-1:0]   d;
        logic [WIDTH-1:0] d_ext;
        br    = br_q;
        ai    = 1'b0;
        bi    = 1'b0;
        d     = '0;
        d_ext = '0;
        for (int i = 0; i < BPC; i++) begin
            ai   = a_q[i];
            bi   = b_q[i];
            d[i] = ai ^ bi ^ br;
            br   = (~ai & bi) | (~(ai ^ bi) & br);
        end
        d_ext[WIDTH-1 -: BPC] = d;
        acc_d = (acc_q >> BPC) | d_ext;
        br_d  = br;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            br_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        sa_q    <= a[WIDTH-1];
                        sb_q    <= b[WIDTH-1];
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> BPC;
                    b_q   <= b_q >> BPC;
                    acc_q <= acc_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        diff_q  <= acc_d;
                        bout_q  <= br_d;
                        // Overflow only possible when operand signs differ.
                        ovf_q   <= (sa_q != sb_q) &&
                                   (acc_d[WIDTH-1] != sa_q);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor16.sv
// Scoreboard bench for serial_subtractor16 (BPC=1 and BPC=4 instances).
// Directed vectors with hand-computed results; monitors check on done.
module tb_serial_subtractor16;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        int          k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] a1 = '0;
    logic [15:0] b1 = '0;
    logic        bin1 = 1'b0;
    logic        busy1, done1, bout1, ovf1;
    logic [15:0] diff1;
    logic        start4 = 1'b0;
    logic [15:0] a4 = '0;
    logic [15:0] b4 = '0;
    logic        bin4 = 1'b0;
    logic        busy4, done4, bout4, ovf4;
    logic [15:0] diff4;

    exp_t q1[$];
    exp_t q4[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor16 #(.WIDTH(16), .BPC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1),
        .bout(bout1), .ovf(ovf1)
    );

    serial_subtractor16 #(.WIDTH(16), .BPC(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4),
        .bout(bout4), .ovf(ovf4)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor for the BPC=1 instance.
    logic [15:0] prev1 = '0;
    logic        pdone1 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev1  = diff1;
            pdone1 = 1'b0;
        end else begin
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("dut1_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    chk("dut1_diff", 32'(diff1), 32'(e.d));
                    chk("dut1_bout", 32'(bout1), 32'(e.bo));
                    chk("dut1_ovf", 32'(ovf1), 32'(e.ov));
                    chk("dut1_latency", 32'(cyc - e.k), 32'd16);
                end
                chk("dut1_done_pulse", 32'(pdone1), 32'd0);
            end else if (diff1 !== prev1) begin
                chk("dut1_diff_stable", 32'(diff1), 32'(prev1));
            end
            prev1  = diff1;
            pdone1 = done1;
        end
    end

    // Monitor for the BPC=4 instance.
    logic [15:0] prev4 = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev4 = diff4;
        end else begin
            if (done4) begin
                if (q4.size() == 0) begin
                    chk("dut4_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q4.pop_front();
                    chk("dut4_diff", 32'(diff4), 32'(e.d));
                    chk("dut4_bout", 32'(bout4), 32'(e.bo));
                    chk("dut4_ovf", 32'(ovf4), 32'(e.ov));
                    chk("dut4_latency", 32'(cyc - e.k), 32'd4);
                end
            end else if (diff4 !== prev4) begin
                chk("dut4_diff_stable", 32'(diff4), 32'(prev4));
            end
            prev4 = diff4;
        end
    end

    task automatic wait_q1_empty();
        int t;
        t = 0;
        while (q1.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (q1.size() != 0) begin
            chk("dut1_timeout", 32'(q1.size()), 32'd0);
            q1.delete();
        end
    endtask

    // Issue one op on the BPC=1 instance and wait for its result.
    task automatic go1(input logic [15:0] a, input logic [15:0] b,
                       input logic bi, input logic [15:0] d,
                       input logic bo, input logic ov);
        exp_t e;
        @(negedge clk);
        a1     = a;
        b1     = b;
        bin1   = bi;
        start1 = 1'b1;
        e.d  = d;
        e.bo = bo;
        e.ov = ov;
        e.k  = cyc + 1;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        a1     = 16'h5A5A;
        b1     = 16'hA5A5;
        bin1   = 1'b1;
        wait_q1_empty();
    endtask

    initial begin
        int   nb;
        exp_t e;
        #1;
        chk("rst_busy", 32'({busy1, busy4}), 32'd0);
        chk("rst_done", 32'({done1, done4}), 32'd0);
        chk("rst_diff", 32'({diff1, diff4}), 32'd0);
        chk("rst_flags", 32'({bout1, ovf1, bout4, ovf4}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic op with busy-length check.
        @(negedge clk);
        a1 = 16'h1234; b1 = 16'h0234; bin1 = 1'b0; start1 = 1'b1;
        e.d = 16'h1000; e.bo = 1'b0; e.ov = 1'b0; e.k = cyc + 1;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy1) nb++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(nb), 32'd16);
        wait_q1_empty();

        go1(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        go1(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        go1(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        go1(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        go1(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Start pulsed mid-run is ignored.
        @(negedge clk);
        a1 = 16'h1234; b1 = 16'h0234; bin1 = 1'b0; start1 = 1'b1;
        e.d = 16'h1000; e.bo = 1'b0; e.ov = 1'b0; e.k = cyc + 1;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        a1 = 16'hFFFF; b1 = 16'h0001; bin1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_q1_empty();
        repeat (20) @(negedge clk);

        // Leave a nonzero result, then abort a run with reset.
        go1(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        @(negedge clk);
        a1 = 16'h1234; b1 = 16'h0234; bin1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_diff", 32'(diff1), 32'd0);
        chk("abort_flags", 32'({bout1, ovf1, done1}), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("abort_diff_held", 32'({diff1, bout1, ovf1}), 32'd0);
        go1(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);

        // BPC=4: start held high, an op every 5 cycles.
        @(negedge clk);
        a4 = 16'hABCD; b4 = 16'h1111; bin4 = 1'b0; start4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e.d = 16'h9ABC; e.bo = 1'b0; e.ov = 1'b0;
            e.k = cyc + 1 + 5 * i;
            q4.push_back(e);
        end
        repeat (11) @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        nb = 0;
        while (q4.size() != 0 && nb < 30) begin
            @(negedge clk);
            nb++;
        end
        chk("dut4_queue_left", 32'(q4.size()), 32'd0);
        repeat (10) @(negedge clk);
        chk("dut1_queue_left", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
